goldschmidt_ctrl: RTL and testbench
===================================

# goldschmidt_ctrl

Control stage for the Goldschmidt divider datapath. Accepts a divide request (N, D, initial approximation IA) over a valid/ready handshake, holds the operands stable on the datapath inputs, and sequences the datapath's shared multiplier through the Goldschmidt iterations. It drives `kSelect`, `ndSelect` and the N/D register enables. It captures the finished quotient into an output register with its own valid/ready handshake. It sits directly upstream of the datapath and consumes the datapath's quotient output.

## Interface
- `ITERS`, default 3: number of Goldschmidt iterations, with a legal range of 1–15. Iteration 0 uses IA as K.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  high only in IDLE.
- `n_in`, `d_in`, `ia_in`  in  16 each  numerator, divisor, initial reciprocal approximation.
- `N`, `D`, `IA`  out  16 each  registered operands to the datapath.
- `kSelect`  out  1  0 selects IA as K; 1 selects K generated from the current D register.
- `ndSelect`  out  2  multiplier operand select: 0 = D, 1 = N, 2 = D register, 3 = N register.
- `nEnable`, `dEnable`  out  1 each  write enables for the datapath's N and D registers.
- `dp_q`  in  16  datapath N-register value (quotient estimate).
- `out_valid`  out  1  quotient valid.
- `out_ready`  in  1  consumer accepts.
- `q`  out  16  registered quotient.
- `div0`  out  1  divide-by-zero flag; qualified by `out_valid`.

## Operation
- The block has five states: IDLE, N_STEP, D_STEP, CAPTURE and DONE.
- Iteration counter `it` is $clog2(ITERS+1) bits wide.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`: register `n_in`/`d_in`/`ia_in` into `N`/`D`/`IA`, clear `it`, and go to N_STEP.
- **N_STEP:**
  - Drives `ndSelect`=1, `kSelect`=0 when `it`==0.
  - Otherwise drives `ndSelect`=3, `kSelect`=1.
  - `nEnable`=1.
  - If `it`==ITERS-1, go to CAPTURE; otherwise go to D_STEP.
- **D_STEP:**
  - Drives `ndSelect`=0, `kSelect`=0 when `it`==0.
  - Otherwise drives `ndSelect`=2, `kSelect`=1.
  - `dEnable`=1.
  - Increment `it` and go to N_STEP.
- N is always updated before D within an iteration, because K is derived from the pre-update D register.
- The final iteration has no D_STEP.
- **CAPTURE:**
  - No enables are asserted.
  - Register `q`←`dp_q`, set `out_valid`, and go to DONE.
- **DONE:**
  - `out_valid`=1.
  - `q`/`div0` are held stable.
  - On `out_ready`: clear `out_valid` and go to IDLE.
- Outside N_STEP and D_STEP: `nEnable`=`dEnable`=0, `ndSelect`=0, `kSelect`=0.
- `in_valid` outside IDLE is ignored, because `in_ready`=0.
- `N`/`D`/`IA` hold their values from acceptance until the next acceptance.

## Timing
- Reset values (asynchronous, immediate on assertion):
  - State is IDLE and `it`=0.
  - `N`=`D`=`IA`=0 and `q`=0.
  - `out_valid`=0, `div0`=0, `nEnable`=`dEnable`=0, `ndSelect`=0, `kSelect`=0, `in_ready`=1.
- Reset asserted mid-operation abandons the operation; no partial result is emitted.
- Accept edge = cycle 0.
- Step cycles occupy cycles 1 … 2·ITERS−1.
- CAPTURE is at cycle 2·ITERS; `out_valid` first rises at cycle 2·ITERS+1. For ITERS=3, `out_valid` rises at cycle 7.
- `dp_q` is sampled in CAPTURE, one cycle after the last `nEnable` edge.
- In DONE with `out_ready`=1, `in_ready` rises the next cycle. There is no same-cycle accept/complete overlap.
- Throughput is one division per 2·ITERS+2 cycles minimum.

## Configuration
- **`GS_DIV0_CHECK_EN` defined:**
  - In IDLE, acceptance with `d_in`==0 goes directly to DONE.
  - That path sets `q`=16'hFFFF and `div0`=1.
  - No enables are asserted on that path; `out_valid` is high from cycle 1.
  - A nonzero `d_in` clears `div0`.
- **`GS_DIV0_CHECK_EN` not defined:**
  - `div0` is tied to 0.
  - `d_in`==0 is sequenced like any other divisor.

## Test plan
- ITERS=3, accept `n_in`=16'h3000, `d_in`=16'h6000, `ia_in`=16'h5555: the ({`ndSelect`,`kSelect`,`nEnable`,`dEnable`}) tuples in cycles 1–5 must be (1,0,1,0), (0,0,0,1), (3,1,1,0), (2,1,0,1), (3,1,1,0); `out_valid` must rise at cycle 7 with `q` equal to the `dp_q` value sampled at cycle 6.
- Hold `out_ready`=0 for 10 cycles in DONE while toggling `in_valid` and `n_in`: `q`, `out_valid`=1 and `N` stay constant and `in_ready`=0; after `out_ready`=1 for one cycle, `in_ready`=1 on the next cycle.
- Pulse `in_valid` with new operands during N_STEP of iteration 1: the operands are not captured and the step sequence is unchanged.
- Assert `reset`=0 asynchronously in D_STEP of iteration 1: all outputs take their reset values before the next edge; after release, `in_ready`=1 and a new request completes normally at cycle 7.
- With `GS_DIV0_CHECK_EN`, accept `d_in`=0: no enable is asserted, `out_valid`=1 at cycle 1, `q`=16'hFFFF, `div0`=1. Without the macro, the same stimulus gives the normal 7-cycle sequence with `div0`=0.
- ITERS=1, accept any operands: a single cycle-1 tuple (1,0,1,0), CAPTURE at cycle 2, and `out_valid` at cycle 3.

Source files
------------

// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl
// ----------------
// Control stage for a Goldschmidt divider datapath. A divide request (N, D,
// initial reciprocal approximation IA) is accepted over a valid/ready
// handshake. The operands are held on the datapath inputs while the shared
// multiplier is sequenced through ITERS iterations. Each iteration is an N
// step followed by a D step, and the last iteration has no D step. The
// finished quotient (datapath N register) is then captured into an output
// register that has its own valid/ready handshake.
//
// Optional feature macro: GS_DIV0_CHECK_EN
//   defined   : a request with d_in == 0 skips sequencing and completes
//               directly with q = all ones and div0 = 1.
//   undefined : div0 is constant 0 and a zero divisor is sequenced normally.
//
// Parameters
//   ITERS   number of Goldschmidt iterations (1..15); iteration 0 uses IA as K
//   DATA_W  operand / quotient width
//
// Ports
//   clk                 clock, rising edge
//   reset               asynchronous reset, active LOW
//   in_valid/in_ready   request handshake (in_ready high only when idle)
//   n_in, d_in, ia_in   request operands
//   N, D, IA            registered operands driven to the datapath
//   kSelect             0: K = IA, 1: K derived from the current D register
//   ndSelect            multiplier operand: 0 D, 1 N, 2 D reg, 3 N reg
//   nEnable, dEnable    datapath N / D register write enables
//   dp_q                datapath N register value (quotient estimate)
//   out_valid/out_ready result handshake
//   q                   registered quotient
//   div0                divide-by-zero flag, qualified by out_valid

module goldschmidt_ctrl #(
  parameter int ITERS  = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] n_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic [DATA_W-1:0] ia_in,
  output logic [DATA_W-1:0] N,
  output logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] IA,
  output logic              kSelect,
  output logic [1:0]        ndSelect,
  output logic              nEnable,
  output logic              dEnable,
  input  logic [DATA_W-1:0] dp_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] q,
  output logic              div0
);

  localparam int                IT_W    = $clog2(ITERS + 1);
  localparam logic [IT_W-1:0]   IT_LAST = IT_W'(ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_N_STEP,
    S_D_STEP,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IT_W-1:0] it;
  logic            accept;
  logic            d_zero;

`ifdef GS_DIV0_CHECK_EN
  assign d_zero = (d_in == '0);
`else
  assign d_zero = 1'b0;
`endif

  assign accept = (state == S_IDLE) && in_valid;

  // Next-state and datapath control decode (Moore outputs from state/it)
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ndSelect  = 2'd0;
    kSelect   = 1'b0;
    nEnable   = 1'b0;
    dEnable   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = d_zero ? S_DONE : S_N_STEP;
      end
      S_N_STEP: begin
        nEnable = 1'b1;
        if (it == '0) begin
          ndSelect = 2'd1;
        end else begin
          ndSelect = 2'd3;
          kSelect  = 1'b1;
        end
        // The last iteration only needs the N update.
        state_nxt = (it == IT_LAST) ? S_CAPTURE : S_D_STEP;
      end
      S_D_STEP: begin
        dEnable = 1'b1;
        if (it == '0) begin
          ndSelect = 2'd0;
        end else begin
          ndSelect = 2'd2;
          kSelect  = 1'b1;
        end
        state_nxt = S_N_STEP;
      end
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, iteration counter, result flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      it        <= '0;
      out_valid <= 1'b0;
      div0      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        it   <= '0;
        div0 <= d_zero;
        if (d_zero) out_valid <= 1'b1;
      end
      if (state == S_D_STEP) it <= it + IT_W'(1);
      if (state == S_CAPTURE) out_valid <= 1'b1;
      if ((state == S_DONE) && out_ready) out_valid <= 1'b0;
    end
  end

  // Operand and quotient registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      N  <= '0;
      D  <= '0;
      IA <= '0;
      q  <= '0;
    end else begin
      if (accept) begin
        N  <= n_in;
        D  <= d_in;
        IA <= ia_in;
        if (d_zero) q <= '1;
      end
      // dp_q already reflects the final N update made in the previous cycle.
      if (state == S_CAPTURE) q <= dp_q;
    end
  end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
module tb_goldschmidt_ctrl;

  localparam int IT = 3;

  logic        clk;
  logic        reset;
  logic        in_valid, in_valid1;
  logic [15:0] n_in, d_in, ia_in;
  logic [15:0] dp_q;
  logic        out_ready, out_ready1;

  logic        in_ready, kSelect, nEnable, dEnable, out_valid, div0;
  logic [1:0]  ndSelect;
  logic [15:0] N, D, IA, q;

  logic        in_ready_1, kSelect_1, nEnable_1, dEnable_1, out_valid_1, div0_1;
  logic [1:0]  ndSelect_1;
  logic [15:0] N_1, D_1, IA_1, q_1;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] exp_q[$];

  goldschmidt_ctrl #(.ITERS(IT)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .n_in(n_in), .d_in(d_in), .ia_in(ia_in), .N(N), .D(D), .IA(IA),
    .kSelect(kSelect), .ndSelect(ndSelect), .nEnable(nEnable), .dEnable(dEnable),
    .dp_q(dp_q), .out_valid(out_valid), .out_ready(out_ready), .q(q), .div0(div0)
  );

  goldschmidt_ctrl #(.ITERS(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready_1),
    .n_in(n_in), .d_in(d_in), .ia_in(ia_in), .N(N_1), .D(D_1), .IA(IA_1),
    .kSelect(kSelect_1), .ndSelect(ndSelect_1), .nEnable(nEnable_1), .dEnable(dEnable_1),
    .dp_q(dp_q), .out_valid(out_valid_1), .out_ready(out_ready1), .q(q_1), .div0(div0_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dp_q changes on the falling edge so it is stable at every rising edge.
  function automatic logic [15:0] pat(input int c);
    return 16'(c * 311) ^ 16'hA5C3;
  endfunction

  always @(negedge clk) cyc <= cyc + 1;
  assign dp_q = pat(cyc);

  // Expected {ndSelect, kSelect, nEnable, dEnable} in cycle k after accept.
  function automatic logic [4:0] tup(input int k, input int iters);
    int it;
    if (k < 1 || k > 2 * iters - 1) return 5'b0;
    if (k % 2 == 1) begin
      it = (k - 1) / 2;
      return (it == 0) ? 5'b01_0_10 : 5'b11_1_10;
    end
    it = (k - 2) / 2;
    return (it == 0) ? 5'b00_0_01 : 5'b10_1_01;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: stray request during N step of iteration 1,
  // 2: reset during D step of iteration 1, 3: 10-cycle result stall
  task automatic run_div(input logic [15:0] n, input logic [15:0] d,
                         input logic [15:0] ia, input int mode);
    int a;
    bit zpath;
    zpath = 1'b0;
`ifdef GS_DIV0_CHECK_EN
    zpath = (d == 16'h0);
`endif
    @(negedge clk);
    chk("idle_rdy", in_ready, 1);
    in_valid = 1'b1; n_in = n; d_in = d; ia_in = ia;
    @(posedge clk);
    a = cyc;
    exp_q.push_back(zpath ? 16'hFFFF : pat(a + 2 * IT));
    @(negedge clk);
    in_valid = 1'b0; n_in = ~n; d_in = ~d; ia_in = ~ia;
    if (zpath) begin
      chk("z_tuple", {ndSelect, kSelect, nEnable, dEnable}, 0);
      chk("z_vld", out_valid, 1);
      chk("z_div0", div0, 1);
    end else begin
      for (int k = 1; k <= 2 * IT - 1; k++) begin
        if (k > 1) @(negedge clk);
        chk($sformatf("tuple_c%0d", k), {ndSelect, kSelect, nEnable, dEnable}, tup(k, IT));
        chk("busy_rdy", in_ready, 0);
        if (mode == 1 && k == 3) begin
          in_valid = 1'b1; n_in = 16'h1111; d_in = 16'h2222; ia_in = 16'h3333;
        end
        if (mode == 1 && k == 4) in_valid = 1'b0;
        if (mode == 2 && k == 4) begin
          #1 reset = 1'b0;
          #1;
          chk("rst_tuple", {ndSelect, kSelect, nEnable, dEnable}, 0);
          chk("rst_rdy", in_ready, 1);
          chk("rst_vld", out_valid, 0);
          chk("rst_div0", div0, 0);
          chk("rst_ops", {N, D}, 0);
          chk("rst_ia_q", {IA, q}, 0);
          void'(exp_q.pop_back());
          @(negedge clk);
          reset = 1'b1;
          return;
        end
      end
      @(negedge clk);
      chk("cap_tuple", {ndSelect, kSelect, nEnable, dEnable}, 0);
      chk("cap_vld", out_valid, 0);
      @(negedge clk);
      chk("vld_rise", out_valid, 1);
      chk("div0_clr", div0, 0);
    end
    chk("N_hold", N, n);
    chk("D_hold", D, d);
    chk("IA_hold", IA, ia);
    if (mode == 3) begin
      for (int s = 0; s < 10; s++) begin
        in_valid = s[0];
        n_in = 16'($urandom);
        @(negedge clk);
        chk("stall_q", q, exp_q[0]);
        chk("stall_vld", out_valid, 1);
        chk("stall_N", N, n);
        chk("stall_rdy", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("q", q, exp_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
    chk("rdy_back", in_ready, 1);
    chk("vld_clr", out_valid, 0);
  endtask

  task automatic run_iters1(input logic [15:0] n);
    int a;
    @(negedge clk);
    in_valid1 = 1'b1; n_in = n; d_in = 16'h4000; ia_in = 16'h8000;
    @(posedge clk);
    a = cyc;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("i1_tuple_c1", {ndSelect_1, kSelect_1, nEnable_1, dEnable_1}, tup(1, 1));
    @(negedge clk);
    chk("i1_cap_tuple", {ndSelect_1, kSelect_1, nEnable_1, dEnable_1}, 0);
    chk("i1_cap_vld", out_valid_1, 0);
    @(negedge clk);
    chk("i1_vld", out_valid_1, 1);
    chk("i1_q", q_1, pat(a + 2));
    @(negedge clk);
    chk("i1_rdy", in_ready_1, 1);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_valid1 = 1'b0;
    n_in = '0; d_in = '0; ia_in = '0;
    out_ready = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("r_rdy", in_ready, 1);
    chk("r_vld", out_valid, 0);
    chk("r_div0", div0, 0);
    chk("r_tuple", {ndSelect, kSelect, nEnable, dEnable}, 0);
    chk("r_ops", {N, D}, 0);
    chk("r_ia_q", {IA, q}, 0);
    reset = 1'b1;

    run_div(16'h3000, 16'h6000, 16'h5555, 3);
    run_div(16'h1234, 16'h4321, 16'h7777, 1);
    run_div(16'h0ABC, 16'h0DEF, 16'h1111, 2);
    run_div(16'h3000, 16'h6000, 16'h5555, 0);
    run_div(16'h0100, 16'h0000, 16'h8000, 0);
    run_div(16'hFFFF, 16'h0001, 16'hFFFF, 0);
    run_iters1(16'h2468);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
